// File: rtl/wind_pkg.sv
// Shared wind-controller constants, bar geometry and types for the Cat vs Dog game logic.
// Consumed by wind_ctl, wind_lfsr and the wind-bar drawing stage.
package wind_pkg;

   localparam int          WIND_MAX     = 10;
   localparam int          PIX_PER_UNIT = 5;
   localparam logic [15:0] LFSR_MASK    = 16'hB400;
   localparam logic [15:0] LFSR_SEED    = 16'hACE1;

   // Wind bar geometry; the indicator offset must stay within +/-55 pixels of the centre.
   localparam int BAR_W = 116;
   localparam int BAR_H = 16;
   localparam int BAR_Y = 40;

   typedef enum logic [1:0] {IDLE, GEN, ANIM, HOLD} wind_state_t;

   typedef logic signed [4:0] wind_t;

endpackage

// File: rtl/wind_lfsr.sv
// 16-bit right-shifting Galois LFSR that steps only when enabled.
// A zero state is never kept: it reloads the seed on the following cycle.
module wind_lfsr
   import wind_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   output logic [15:0] lfsr_state,
   output logic [4:0]  cand
);

   logic [15:0] lfsr_step;

   always_comb begin
      lfsr_step = {1'b0, lfsr_state[15:1]} ^ (lfsr_state[0] ? LFSR_MASK : 16'h0000);
      cand      = lfsr_step[4:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_state <= LFSR_SEED;
      end else if (lfsr_state == 16'h0000) begin
         lfsr_state <= LFSR_SEED;
      end else if (step) begin
         lfsr_state <= lfsr_step;
      end
   end

endmodule

// File: rtl/wind_ctl.sv
// Per-turn wind controller: draws a wind value by rejection sampling an LFSR and
// animates the bar indicator toward it. Optional macro WIND_FORCE_EN adds a forced-wind override.
module wind_ctl
   import wind_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              new_turn,
   input  logic              frame_tick,
`ifdef WIND_FORCE_EN
   input  logic              wind_force_en,
   input  logic signed [4:0] wind_force_val,
`endif
   output logic signed [4:0] wind_out,
   output logic              wind_valid,
   output logic              busy,
   output logic signed [6:0] wind_disp
);

   wind_state_t       state_q, state_d;
   logic              pending_q, pending_d;
   logic signed [4:0] wind_d;
   logic signed [6:0] disp_d;
   logic signed [6:0] goal;
   logic              lfsr_en;
   logic [15:0]       lfsr_state;
   logic [4:0]        cand;
   logic              force_hit;
   logic signed [4:0] force_wind;

   function automatic wind_t sat_wind(input wind_t v);
      if (int'(v) > WIND_MAX) return wind_t'(WIND_MAX);
      if (int'(v) < -WIND_MAX) return wind_t'(-WIND_MAX);
      return v;
   endfunction

`ifdef WIND_FORCE_EN
   assign force_hit  = wind_force_en;
   assign force_wind = sat_wind(wind_force_val);
`else
   assign force_hit  = 1'b0;
   assign force_wind = '0;
`endif

   wind_lfsr u_lfsr (
      .clk        (clk),
      .rst        (rst),
      .step       (lfsr_en),
      .lfsr_state (lfsr_state),
      .cand       (cand)
   );

   // Indicator goal in pixels; WIND_MAX*PIX_PER_UNIT fits a signed 7-bit offset.
   assign goal = 7'(int'(wind_out) * PIX_PER_UNIT);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      wind_d    = wind_out;
      disp_d    = wind_disp;
      lfsr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (new_turn) state_d = GEN;
         end
         GEN: begin
            lfsr_en = 1'b1;
            if (new_turn) pending_d = 1'b1;
            if (force_hit) begin
               wind_d  = force_wind;
               state_d = ANIM;
            end else if (lfsr_state != 16'h0000 && cand <= 5'(2 * WIND_MAX)) begin
               wind_d  = wind_t'(int'(cand) - WIND_MAX);
               state_d = ANIM;
            end
         end
         ANIM: begin
            if (new_turn) pending_d = 1'b1;
            if (wind_disp == goal) begin
               state_d = HOLD;
            end else if (frame_tick) begin
               disp_d = (wind_disp < goal) ? wind_disp + 7'sd1 : wind_disp - 7'sd1;
            end
         end
         HOLD: begin
            // A queued request gets a single valid cycle before the next draw.
            if (pending_q || new_turn) begin
               state_d   = GEN;
               pending_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pending_q  <= 1'b0;
         wind_out   <= '0;
         wind_disp  <= '0;
         wind_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         wind_out   <= wind_d;
         wind_disp  <= disp_d;
         wind_valid <= (state_d == HOLD);
         busy       <= (state_d == GEN) || (state_d == ANIM);
      end
   end

endmodule

// File: tb/tb_wind_ctl.sv
// Directed self-checking bench for wind_ctl; forced-wind scenarios build only with WIND_FORCE_EN.
module tb_wind_ctl;

   logic              clk = 1'b0;
   logic              rst;
   logic              new_turn;
   logic              frame_tick;
`ifdef WIND_FORCE_EN
   logic              wind_force_en;
   logic signed [4:0] wind_force_val;
`endif
   logic signed [4:0] wind_out;
   logic              wind_valid;
   logic              busy;
   logic signed [6:0] wind_disp;

   int n_checks = 0;
   int n_fail   = 0;

   wind_ctl dut (
      .clk            (clk),
      .rst            (rst),
      .new_turn       (new_turn),
      .frame_tick     (frame_tick),
`ifdef WIND_FORCE_EN
      .wind_force_en  (wind_force_en),
      .wind_force_val (wind_force_val),
`endif
      .wind_out       (wind_out),
      .wind_valid     (wind_valid),
      .busy           (busy),
      .wind_disp      (wind_disp)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      new_turn   = 1'b0;
      frame_tick = 1'b0;
`ifdef WIND_FORCE_EN
      wind_force_en  = 1'b0;
      wind_force_val = '0;
`endif
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      repeat (1000) step();
      n_checks++; if (wind_out !== 5'sd0) begin n_fail++; $display("FAIL rst_wind_out: got %0d want 0", wind_out); end
      n_checks++; if (wind_disp !== 7'sd0) begin n_fail++; $display("FAIL rst_wind_disp: got %0d want 0", wind_disp); end
      n_checks++; if (wind_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wind_valid: got %b want 0", wind_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (dut.u_lfsr.lfsr_state !== 16'hACE1) begin n_fail++; $display("FAIL rst_lfsr_idle: got %h want ace1", dut.u_lfsr.lfsr_state); end
   endtask

   // First draw from the seed: ACE1 -> E270, candidate 16 accepted, wind 6, goal 30 px.
   task automatic test_lfsr_path();
      new_turn = 1'b1;
      step();
      new_turn = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_gen: got %b want 1", busy); end
      n_checks++; if (dut.u_lfsr.lfsr_state !== 16'hACE1) begin n_fail++; $display("FAIL t1_lfsr_pre: got %h want ace1", dut.u_lfsr.lfsr_state); end
      step();
      n_checks++; if (dut.u_lfsr.lfsr_state !== 16'hE270) begin n_fail++; $display("FAIL t1_lfsr_step: got %h want e270", dut.u_lfsr.lfsr_state); end
      n_checks++; if (wind_out !== 5'sd6) begin n_fail++; $display("FAIL t1_wind: got %0d want 6", wind_out); end
      ticks(29);
      n_checks++; if (wind_disp !== 7'sd29) begin n_fail++; $display("FAIL t1_disp29: got %0d want 29", wind_disp); end
      n_checks++; if (wind_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_early: got %b want 0", wind_valid); end
      ticks(1);
      n_checks++; if (wind_disp !== 7'sd30) begin n_fail++; $display("FAIL t1_disp30: got %0d want 30", wind_disp); end
      n_checks++; if (wind_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid: got %b want 1", wind_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_hold: got %b want 0", busy); end
   endtask

   // Second draw: 7138 (c=24) and 389C (c=28) rejected, 1C4E (c=14) accepted, wind 4.
   task automatic test_rejection();
      new_turn = 1'b1;
      step();
      new_turn = 1'b0;
      n_checks++; if (wind_valid !== 1'b0) begin n_fail++; $display("FAIL t2_valid_drop: got %b want 0", wind_valid); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t2_busy: got %b want 1", busy); end
      step();
      n_checks++; if (dut.u_lfsr.lfsr_state !== 16'h7138) begin n_fail++; $display("FAIL t2_lfsr_a: got %h want 7138", dut.u_lfsr.lfsr_state); end
      n_checks++; if (wind_out !== 5'sd6) begin n_fail++; $display("FAIL t2_reject_a: got %0d want 6", wind_out); end
      step();
      n_checks++; if (dut.u_lfsr.lfsr_state !== 16'h389C) begin n_fail++; $display("FAIL t2_lfsr_b: got %h want 389c", dut.u_lfsr.lfsr_state); end
      n_checks++; if (wind_out !== 5'sd6) begin n_fail++; $display("FAIL t2_reject_b: got %0d want 6", wind_out); end
      step();
      n_checks++; if (dut.u_lfsr.lfsr_state !== 16'h1C4E) begin n_fail++; $display("FAIL t2_lfsr_c: got %h want 1c4e", dut.u_lfsr.lfsr_state); end
      n_checks++; if (wind_out !== 5'sd4) begin n_fail++; $display("FAIL t2_wind: got %0d want 4", wind_out); end
      ticks(10);
      n_checks++; if (wind_disp !== 7'sd20) begin n_fail++; $display("FAIL t2_disp: got %0d want 20", wind_disp); end
      n_checks++; if (wind_valid !== 1'b1) begin n_fail++; $display("FAIL t2_valid: got %b want 1", wind_valid); end
   endtask

   // Third draw 0E27 -> wind -3 (goal -15); two requests mid-animation queue one more draw B313 -> wind 9.
   task automatic test_pending();
      new_turn = 1'b1;
      step();
      new_turn = 1'b0;
      step();
      n_checks++; if (wind_out !== -5'sd3) begin n_fail++; $display("FAIL t3_wind: got %0d want -3", wind_out); end
      for (int i = 0; i < 35; i++) begin
         frame_tick = 1'b1;
         if (i == 5 || i == 10) new_turn = 1'b1;
         step();
         frame_tick = 1'b0;
         new_turn   = 1'b0;
         step();
      end
      n_checks++; if (wind_disp !== -7'sd15) begin n_fail++; $display("FAIL t3_disp: got %0d want -15", wind_disp); end
      n_checks++; if (wind_valid !== 1'b1) begin n_fail++; $display("FAIL t3_valid_pulse: got %b want 1", wind_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t3_busy_hold: got %b want 0", busy); end
      step();
      n_checks++; if (wind_valid !== 1'b0) begin n_fail++; $display("FAIL t3_valid_one_cycle: got %b want 0", wind_valid); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t3_busy_regen: got %b want 1", busy); end
      step();
      n_checks++; if (wind_out !== 5'sd9) begin n_fail++; $display("FAIL t4_wind: got %0d want 9", wind_out); end
      ticks(60);
      n_checks++; if (wind_disp !== 7'sd45) begin n_fail++; $display("FAIL t4_disp: got %0d want 45", wind_disp); end
      n_checks++; if (wind_valid !== 1'b1) begin n_fail++; $display("FAIL t4_valid: got %b want 1", wind_valid); end
      repeat (5) step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t4_no_third_gen: got %b want 0", busy); end
      n_checks++; if (dut.u_lfsr.lfsr_state !== 16'hB313) begin n_fail++; $display("FAIL t4_lfsr_idle: got %h want b313", dut.u_lfsr.lfsr_state); end
      ticks(3);
      n_checks++; if (wind_disp !== 7'sd45) begin n_fail++; $display("FAIL hold_tick_ignored: got %0d want 45", wind_disp); end
   endtask

   // Fifth draw ED89 -> wind -1, interrupted by reset while the indicator is moving.
   task automatic test_async_reset();
      new_turn = 1'b1;
      step();
      new_turn = 1'b0;
      step();
      n_checks++; if (wind_out !== -5'sd1) begin n_fail++; $display("FAIL t5_wind: got %0d want -1", wind_out); end
      ticks(10);
      n_checks++; if (wind_disp !== 7'sd35) begin n_fail++; $display("FAIL t5_disp_pre: got %0d want 35", wind_disp); end
      #3;
      rst = 1'b1;
      #1;
      n_checks++; if (wind_out !== 5'sd0) begin n_fail++; $display("FAIL arst_wind_out: got %0d want 0", wind_out); end
      n_checks++; if (wind_disp !== 7'sd0) begin n_fail++; $display("FAIL arst_disp: got %0d want 0", wind_disp); end
      n_checks++; if (wind_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", wind_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
      n_checks++; if (dut.u_lfsr.lfsr_state !== 16'hACE1) begin n_fail++; $display("FAIL arst_lfsr: got %h want ace1", dut.u_lfsr.lfsr_state); end
      step();
      rst = 1'b0;
      step();
   endtask

`ifdef WIND_FORCE_EN
   task automatic test_force();
      do_reset();
      wind_force_en  = 1'b1;
      wind_force_val = 5'sd7;
      new_turn = 1'b1;
      step();
      new_turn = 1'b0;
      step();
      n_checks++; if (wind_out !== 5'sd7) begin n_fail++; $display("FAIL f7_wind: got %0d want 7", wind_out); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL f7_busy: got %b want 1", busy); end
      n_checks++; if (dut.u_lfsr.lfsr_state !== 16'hE270) begin n_fail++; $display("FAIL f7_lfsr_step: got %h want e270", dut.u_lfsr.lfsr_state); end
      ticks(34);
      n_checks++; if (wind_valid !== 1'b0) begin n_fail++; $display("FAIL f7_valid_early: got %b want 0", wind_valid); end
      ticks(1);
      n_checks++; if (wind_disp !== 7'sd35) begin n_fail++; $display("FAIL f7_disp: got %0d want 35", wind_disp); end
      n_checks++; if (wind_valid !== 1'b1) begin n_fail++; $display("FAIL f7_valid: got %b want 1", wind_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL f7_busy_hold: got %b want 0", busy); end
   endtask

   task automatic test_force_sat();
      do_reset();
      wind_force_en  = 1'b1;
      wind_force_val = -5'sd15;
      new_turn = 1'b1;
      step();
      new_turn = 1'b0;
      step();
      n_checks++; if (wind_out !== -5'sd10) begin n_fail++; $display("FAIL fsat_neg_wind: got %0d want -10", wind_out); end
      ticks(49);
      n_checks++; if (wind_valid !== 1'b0) begin n_fail++; $display("FAIL fsat_neg_early: got %b want 0", wind_valid); end
      ticks(1);
      n_checks++; if (wind_disp !== -7'sd50) begin n_fail++; $display("FAIL fsat_neg_disp: got %0d want -50", wind_disp); end
      n_checks++; if (wind_valid !== 1'b1) begin n_fail++; $display("FAIL fsat_neg_valid: got %b want 1", wind_valid); end
      wind_force_val = 5'sd10;
      new_turn = 1'b1;
      step();
      new_turn = 1'b0;
      step();
      n_checks++; if (wind_out !== 5'sd10) begin n_fail++; $display("FAIL fpos_wind: got %0d want 10", wind_out); end
      ticks(99);
      n_checks++; if (wind_disp !== 7'sd49) begin n_fail++; $display("FAIL fpos_disp99: got %0d want 49", wind_disp); end
      n_checks++; if (wind_valid !== 1'b0) begin n_fail++; $display("FAIL fpos_early: got %b want 0", wind_valid); end
      ticks(1);
      n_checks++; if (wind_disp !== 7'sd50) begin n_fail++; $display("FAIL fpos_disp: got %0d want 50", wind_disp); end
      n_checks++; if (wind_valid !== 1'b1) begin n_fail++; $display("FAIL fpos_valid: got %b want 1", wind_valid); end
   endtask
`endif

   initial begin
      test_reset();
      test_lfsr_path();
      test_rejection();
      test_pending();
      test_async_reset();
`ifdef WIND_FORCE_EN
      test_force();
      test_force_sat();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
